rv_iopmp_tl_arbiter: RTL



---
 rtl/rv_iopmp_tl_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/rv_iopmp_tl_arbiter.sv
// Multi-channel front end for the IOPMP matcher: arbitrates NUM_CH requesters onto
// one check port, keeps a single check in flight, and routes the verdict back.
package rv_iopmp_pkg;
  typedef enum logic [1:0] {
    ACC_NONE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2,
    ACC_EXEC  = 2'd3
  } access_t;
endpackage

module rv_iopmp_tl_arbiter
  import rv_iopmp_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int NUMBER_MASTERS = 2,
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int NbW      = $clog2(DATA_WIDTH/8) + 1,
  localparam int SidWidth = (NUMBER_MASTERS == 1) ? 1 : $clog2(NUMBER_MASTERS),
  localparam int IdxW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_CH-1:0]                   req_valid_i,
  output logic [NUM_CH-1:0]                   req_ready_o,
  input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]   req_len_i,
  input  logic [NUM_CH-1:0][NbW-1:0]          req_nbytes_i,
  input  logic [NUM_CH-1:0][SidWidth-1:0]     req_sid_i,
  input  access_t [NUM_CH-1:0]                req_access_i,
  output logic [NUM_CH-1:0]                   rsp_valid_o,
  input  logic [NUM_CH-1:0]                   rsp_ready_i,
  output logic [NUM_CH-1:0]                   rsp_allow_o,
  output logic [NUM_CH-1:0]                   rsp_timeout_o,
  output logic                                chk_en_o,
  output logic [ADDR_WIDTH-1:0]               chk_addr_o,
  output logic [ADDR_WIDTH-1:0]               chk_len_o,
  output logic [NbW-1:0]                      chk_nbytes_o,
  output logic [SidWidth-1:0]                 chk_sid_o,
  output access_t                             chk_access_o,
  input  logic                                chk_ready_i,
  input  logic                                chk_valid_i,
  input  logic                                chk_allow_i,
  input  logic                                stall_i,
  output logic                                busy_o,
  output logic [IdxW-1:0]                     grant_idx_o
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] len;
    logic [NbW-1:0]        nbytes;
    logic [SidWidth-1:0]   sid;
    access_t               access;
  } chk_req_t;

  state_t          state_q, state_d;
  chk_req_t        req_q;
  logic [IdxW-1:0] gnt_q, ptr_q, gnt_idx;
  logic [TW-1:0]   timer_q;
  logic            allow_q, tmo_q;
  logic            gnt_found, accept, issue_fire, expire, rsp_fire;
  int              cand;

  // Search order starts at the pointer for round-robin, at 0 for fixed priority.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = (ARB_MODE == 1) ? i : ((int'(ptr_q) + i) % NUM_CH);
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = IdxW'(cand);
      end
    end
  end

  // Grant is suppressed during reset so req_ready reads 0 while rst_i is high.
  assign accept     = (state_q == IDLE) && !stall_i && gnt_found && !rst_i;
  assign issue_fire = chk_en_o && chk_ready_i;
  assign expire     = (TIMEOUT_CYCLES != 0) && (timer_q == TMAX);
  assign rsp_fire   = (state_q == RESP) && rsp_ready_i[gnt_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = ISSUE;
      ISSUE: if (issue_fire) state_d = WAIT;
      WAIT:  if (chk_valid_i || expire) state_d = RESP;
      RESP:  if (rsp_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
      timer_q <= '0;
      allow_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q <= '{addr:   req_addr_i[gnt_idx],
                   len:    req_len_i[gnt_idx],
                   nbytes: req_nbytes_i[gnt_idx],
                   sid:    req_sid_i[gnt_idx],
                   access: req_access_i[gnt_idx]};
        gnt_q <= gnt_idx;
      end
      if (state_q == ISSUE) timer_q <= '0;
      else if (state_q == WAIT) timer_q <= timer_q + TW'(1);
      // A result arriving on the expiry cycle takes precedence over the timeout.
      if (state_q == WAIT) begin
        if (chk_valid_i) begin
          allow_q <= chk_allow_i;
          tmo_q   <= 1'b0;
        end else if (expire) begin
          allow_q <= 1'b0;
          tmo_q   <= 1'b1;
        end
      end
      if (rsp_fire)
        ptr_q <= (gnt_q == IdxW'(NUM_CH - 1)) ? '0 : gnt_q + IdxW'(1);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign req_ready_o[c]   = accept && (gnt_idx == IdxW'(c));
    assign rsp_valid_o[c]   = (state_q == RESP) && (gnt_q == IdxW'(c));
    assign rsp_allow_o[c]   = rsp_valid_o[c] && allow_q;
    assign rsp_timeout_o[c] = rsp_valid_o[c] && tmo_q;
  end

  assign chk_en_o     = (state_q == ISSUE) && !stall_i;
  assign chk_addr_o   = req_q.addr;
  assign chk_len_o    = req_q.len;
  assign chk_nbytes_o = req_q.nbytes;
  assign chk_sid_o    = req_q.sid;
  assign chk_access_o = req_q.access;
  assign busy_o       = (state_q != IDLE);
  assign grant_idx_o  = busy_o ? gnt_q : '0;

endmodule
